// File: rtl/interp_mac_scheduler.sv
// Serial 8-tap interpolation scheduler sharing one MCM tap bank, one tap per cycle.
// Optional output clip to [0, 2^BIT_DEPTH-1] when INTERP_CLIP_EN is defined.
module interp_mac_scheduler #(
  parameter int         BIT_DEPTH = 8,
  parameter logic [7:0] TAP_NEG   = 8'b1010_0101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_frac,
  input  logic        in_sol,
  output logic [31:0] mcm_x,
  output logic [2:0]  mcm_tap,
  output logic [3:0]  mcm_frac,
  input  logic [31:0] mcm_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e             state_q, state_d;
  logic [15:0]        win_q [8];
  logic [15:0]        win_d [8];
  logic [3:0]         cnt_q, cnt_d;
  logic signed [31:0] acc_q, acc_d;
  logic [2:0]         tap_q, tap_d;
  logic [3:0]         frac_q, frac_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_data_q, out_data_d;

  logic               accept;
  logic signed [31:0] acc_next;
  logic [15:0]        result;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // The bank is combinational, so its operands are decoded straight from state.
  always_comb begin
    mcm_x    = '0;
    mcm_tap  = '0;
    mcm_frac = '0;
    if (state_q == S_MAC) begin
      mcm_x    = {{16{win_q[tap_q][15]}}, win_q[tap_q]};
      mcm_tap  = tap_q;
      mcm_frac = frac_q;
    end
  end

  assign acc_next = TAP_NEG[tap_q] ? acc_q - $signed(mcm_y) : acc_q + $signed(mcm_y);

`ifdef INTERP_CLIP_EN
  localparam int PIX_MAX = (1 << BIT_DEPTH) - 1;
  logic signed [31:0] rounded;
  assign rounded = (acc_next + 32'sd32) >>> 6;
  always_comb begin
    if (rounded < 0)
      result = '0;
    else if (rounded > PIX_MAX)
      result = PIX_MAX[15:0];
    else
      result = rounded[15:0];
  end
`else
  assign result = 16'((acc_next + 32'sd32) >>> 6);
`endif

  // NOTE: every _d gets its _q as a default first so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    frac_d      = frac_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int k = 0; k < 7; k++)
            win_d[k] = in_sol ? 16'd0 : win_q[k+1];
          win_d[7] = in_data;
          cnt_d    = in_sol ? 4'd1 : ((cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1);
          if (cnt_d == 4'd8) begin
            if (in_frac == 4'd0) begin
              out_data_d  = win_d[3];
              out_valid_d = 1'b1;
              state_d     = S_OUT;
            end else begin
              acc_d   = '0;
              tap_d   = '0;
              frac_d  = in_frac;
              state_d = S_MAC;
            end
          end
        end
      end
      S_MAC: begin
        acc_d = acc_next;
        tap_d = tap_q + 3'd1;
        if (tap_q == 3'd7) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the window is reset explicitly because a reset must discard any partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      tap_q       <= '0;
      frac_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      frac_q      <= frac_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_interp_mac_scheduler.sv
// Scoreboard bench for interp_mac_scheduler: queue-based window model plus an MCM bank model.
// Expectations follow INTERP_CLIP_EN the same way the build does.
module tb_interp_mac_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_frac;
  logic        in_sol;
  logic [31:0] mcm_x;
  logic [2:0]  mcm_tap;
  logic [3:0]  mcm_frac;
  logic [31:0] mcm_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  interp_mac_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_frac(in_frac), .in_sol(in_sol),
    .mcm_x(mcm_x), .mcm_tap(mcm_tap), .mcm_frac(mcm_frac), .mcm_y(mcm_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int coef [8][16];
  int sgn  [8] = '{-1, 1, -1, 1, 1, -1, 1, -1};
  int half_pel [8] = '{1, 4, 11, 40, 40, 11, 4, 1};

  // Shared MCM bank model: coefficient magnitude times the signed sample.
  assign mcm_y = $signed(mcm_x) * coef[mcm_tap][mcm_frac];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          mq[$];
  logic [15:0] exp_q[$];
  bit          rand_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [15:0] ref_result(input int f);
    int acc, t, r;
    if (f == 0) return 16'(mq[3]);
    acc = 0;
    for (int k = 0; k < 8; k++) acc += sgn[k] * coef[k][f] * mq[k];
    t = acc + 32;
    r = (t >= 0) ? t / 64 : -((-t + 63) / 64);
`ifdef INTERP_CLIP_EN
    if (r < 0) r = 0;
    if (r > 255) r = 255;
`endif
    return 16'(r);
  endfunction

  function automatic void model_accept(input logic [15:0] d, input logic [3:0] f, input logic s);
    if (s) mq.delete();
    mq.push_back(int'($signed(d)));
    if (mq.size() > 8) void'(mq.pop_front());
    if (mq.size() == 8) exp_q.push_back(ref_result(int'(f)));
  endfunction

  task automatic send(input logic [15:0] d, input logic [3:0] f, input logic s);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; in_data = d; in_frac = f; in_sol = s;
    model_accept(d, f, s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_frac  = 4'($urandom);
    in_sol   = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_after_release_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  // Monitor: pop one expectation per completed output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_out: got %0d with no expected output", out_data);
        end else begin
          check("sb_out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int lat, seen;
    logic [15:0] held;
    for (int t = 0; t < 8; t++)
      for (int f = 0; f < 16; f++)
        coef[t][f] = (f == 8) ? half_pel[t] : int'($urandom_range(0, 63));

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_frac = '0; in_sol = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_mcm_x", mcm_x, 32'd0);
    check("rst_mcm_tap_frac", {25'd0, mcm_tap, mcm_frac}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Priming: seven accepts give nothing, the eighth starts a MAC job.
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      send(16'($urandom_range(0, 255)), 4'd5, 1'b0);
      if (out_valid) seen++;
    end
    check("priming_no_out", seen, 0);
    send(16'($urandom_range(0, 255)), 4'd5, 1'b0);
    wait_out(lat);
    check("frac5_latency", lat, 9);
    release_out();

    // Integer position.
    for (int i = 1; i <= 8; i++)
      send(16'(i * 10), (i == 8) ? 4'd0 : 4'($urandom_range(1, 15)), i == 1);
    check("frac0_mcm_tap", {29'd0, mcm_tap}, 32'd0);
    wait_out(lat);
    check("frac0_latency", lat, 1);
    check("frac0_out_data", {16'd0, out_data}, 32'd40);
    release_out();

    // Constant input with half-pel taps, then backpressure.
    for (int i = 0; i < 8; i++)
      send(16'd100, (i == 7) ? 4'd8 : 4'($urandom_range(0, 15)), i == 0);
    for (int i = 0; i < 8; i++) begin
      check("const_mcm_tap", {29'd0, mcm_tap}, i);
      check("const_mcm_frac_x", {mcm_frac, mcm_x[27:0]}, {4'd8, 28'd100});
      @(posedge clk); #1;
    end
    check("const_out_valid", {31'd0, out_valid}, 32'd1);
    check("const_out_data", {16'd0, out_data}, 32'd100);
    held = out_data;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== held || in_ready) seen++;
    end
    check("backpressure_stable", seen, 0);
    release_out();

    // Clip case.
    for (int i = 0; i < 8; i++)
      send((i == 3 || i == 4) ? 16'd255 : 16'd0, (i == 7) ? 4'd8 : 4'd1, i == 0);
    wait_out(lat);
`ifdef INTERP_CLIP_EN
    check("clip_out_data", {16'd0, out_data}, 32'd255);
`else
    check("clip_out_data", {16'd0, out_data}, 32'd319);
`endif
    release_out();

    // Reset mid-MAC at tap 4.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 4'($urandom_range(1, 15)), i == 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort_at_tap4", {29'd0, mcm_tap}, 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_mcm_tap", {29'd0, mcm_tap}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    mq.delete();
    rst = 1'b0;
    #1;
    check("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'd123, 4'd7, 1'b1);
    seen = 0;
    repeat (12) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("post_abort_no_out", seen, 0);
    for (int i = 0; i < 7; i++) send(16'($urandom), 4'($urandom_range(0, 15)), 1'b0);

    // Randomized traffic with random backpressure and occasional start-of-line.
    rand_phase = 1;
    for (int i = 0; i < 300; i++)
      send(16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
    rand_phase = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    seen = 0;
    while (exp_q.size() != 0 && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
